sweep_scheduler: RTL and testbench



---
 rtl/sweep_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_sweep_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_scheduler.sv
// Round-robin front end sharing one frequency sweeper between NUM_REQ requesters.
// Define SWEEP_SCHED_TIMEOUT_EN to build the RUN-state timeout counter (done_err = 2'b01).
module sweep_scheduler #(
    parameter int          NUM_REQ        = 2,
    parameter int          ID_W           = 3,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*80-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [79:0]           sw_fifo_data,
    output logic                  sw_fifo_empty,
    input  logic                  sw_fifo_rd_en,
    input  logic                  sw_sweep_done,
    input  logic                  pd_data_valid,
    output logic                  busy,
    output logic                  done_valid,
    output logic [ID_W-1:0]       done_id,
    output logic [15:0]           done_points,
    output logic [1:0]            done_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OFFER,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic [79:0]     r_instr;
    logic [ID_W-1:0] r_id;
    logic [15:0]     r_points;
    logic            r_done_prev;
    logic [ID_W-1:0] r_done_id;
    logic [15:0]     r_done_points;
    logic [1:0]      r_done_err;

    logic            w_found;
    logic [ID_W-1:0] w_winner;
    logic [ID_W-1:0] w_rr_nxt;
    logic [79:0]     w_sel_data;
    logic            w_reject;
    logic            w_edge;
    logic            w_timeout;
    logic [15:0]     w_points_inc;

    // First asserted request at or after the pointer, searching cyclically.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!w_found && req_valid[j] &&
                    (j == (32'(r_rr_ptr) + i) % NUM_REQ)) begin
                    w_found  = 1'b1;
                    w_winner = ID_W'(j);
                end
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (w_winner == ID_W'(j)) begin
                w_sel_data = req_data[j*80 +: 80];
            end
        end
    end

    assign w_rr_nxt     = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + ID_W'(1);
    assign w_reject     = (w_sel_data[47:32] == 16'd0);
    assign w_edge       = sw_sweep_done & ~r_done_prev;
    assign w_points_inc = (pd_data_valid && (r_points != 16'hFFFF)) ? r_points + 16'd1 : r_points;

`ifdef SWEEP_SCHED_TIMEOUT_EN
    logic [31:0] r_tcnt;

    assign w_timeout = (r_tcnt == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt <= '0;
        end else if (r_state == S_OFFER) begin
            r_tcnt <= '0;
        end else if (r_state == S_RUN) begin
            r_tcnt <= r_tcnt + 32'd1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_instr       <= '0;
            r_id          <= '0;
            r_points      <= '0;
            r_done_prev   <= 1'b0;
            r_done_id     <= '0;
            r_done_points <= '0;
            r_done_err    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_done_prev <= sw_sweep_done;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_instr  <= w_sel_data;
                        r_id     <= w_winner;
                        r_rr_ptr <= w_rr_nxt;
                        if (w_reject) begin
                            r_done_id     <= w_winner;
                            r_done_points <= '0;
                            r_done_err    <= 2'b10;
                        end
                    end
                end
                S_OFFER: begin
                    r_points <= '0;
                end
                S_RUN: begin
                    r_points <= w_points_inc;
                    // A done edge outranks a simultaneous timeout expiry.
                    if (w_edge || w_timeout) begin
                        r_done_id     <= r_id;
                        r_done_points <= w_points_inc;
                        r_done_err    <= w_edge ? 2'b00 : 2'b01;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = '0;
        sw_fifo_empty = 1'b1;
        busy          = (r_state != S_IDLE);
        done_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = w_reject ? S_DONE : S_OFFER;
                    for (int unsigned j = 0; j < NUM_REQ; j++) begin
                        req_ready[j] = reset_n && (w_winner == ID_W'(j));
                    end
                end
            end
            S_OFFER: begin
                sw_fifo_empty = 1'b0;
                if (sw_fifo_rd_en) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_edge || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_valid  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign sw_fifo_data = r_instr;
    assign done_id      = r_done_id;
    assign done_points  = r_done_points;
    assign done_err     = r_done_err;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler: transaction-level reference model plus literal checks.
module tb_sweep_scheduler;

    localparam int          NUM_REQ = 2;
    localparam int          ID_W    = 3;
    localparam logic [31:0] TO      = 32'd100;
`ifdef SWEEP_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [79:0] I0   = {32'h0100_0000, 16'd4, 32'h0001_0000};
    localparam logic [79:0] I1   = {32'h0200_0000, 16'd8, 32'h0000_0100};
    localparam logic [79:0] IREJ = {32'h0300_0000, 16'd0, 32'h0000_0010};

    logic                  clk;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*80-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [79:0]           sw_fifo_data;
    logic                  sw_fifo_empty;
    logic                  sw_fifo_rd_en;
    logic                  sw_sweep_done;
    logic                  pd_data_valid;
    logic                  busy;
    logic                  done_valid;
    logic [ID_W-1:0]       done_id;
    logic [15:0]           done_points;
    logic [1:0]            done_err;

    sweep_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .ID_W           (ID_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .sw_fifo_data  (sw_fifo_data),
        .sw_fifo_empty (sw_fifo_empty),
        .sw_fifo_rd_en (sw_fifo_rd_en),
        .sw_sweep_done (sw_sweep_done),
        .pd_data_valid (pd_data_valid),
        .busy          (busy),
        .done_valid    (done_valid),
        .done_id       (done_id),
        .done_points   (done_points),
        .done_err      (done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int grants[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: job held by the scheduler, what it is waiting for, last record.
    int          m_rr;
    bit          m_offer, m_run, m_rep, m_prev;
    logic [79:0] m_instr;
    int          m_id, m_pts, m_elap;
    int          rec_id, rec_pts, rec_err;

    task automatic model_reset();
        m_rr = 0; m_offer = 0; m_run = 0; m_rep = 0; m_prev = 0;
        m_instr = '0; m_id = 0; m_pts = 0; m_elap = 0;
        rec_id = 0; rec_pts = 0; rec_err = 0;
    endtask

    task automatic model_report(input int err, input int pts);
        rec_id = m_id; rec_pts = pts; rec_err = err;
        m_run = 0; m_rep = 1;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_ready;
        int w;
        int j;
        int p;
        if (!reset_n) model_reset();
        exp_ready = '0;
        w = -1;
        if (reset_n && !(m_offer || m_run || m_rep)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (m_rr + k) % NUM_REQ;
                if (w < 0 && req_valid[j]) w = j;
            end
        end
        if (w >= 0) exp_ready[w] = 1'b1;

        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, m_offer || m_run || m_rep);
        chk("done_valid", done_valid, m_rep);
        chk("sw_fifo_empty", sw_fifo_empty, !m_offer);
        if (!reset_n) chk("sw_fifo_data_rst", sw_fifo_data, 80'd0);
        else if (m_offer) chk("sw_fifo_data", sw_fifo_data, m_instr);
        chk("done_id", done_id, rec_id);
        chk("done_points", done_points, rec_pts);
        chk("done_err", done_err, rec_err);

        if (reset_n) begin
            if (m_rep) begin
                m_rep = 0;
            end else if (w >= 0) begin
                m_rr    = (w + 1) % NUM_REQ;
                m_id    = w;
                m_instr = req_data[w*80 +: 80];
                if (m_instr[47:32] == 16'd0) model_report(2, 0);
                else m_offer = 1;
            end else if (m_offer) begin
                if (sw_fifo_rd_en) begin
                    m_offer = 0; m_run = 1; m_pts = 0; m_elap = 0;
                end
            end else if (m_run) begin
                p = m_pts + (pd_data_valid ? 1 : 0);
                if (p > 65535) p = 65535;
                if (sw_sweep_done && !m_prev) model_report(0, p);
                else if (TO_EN && m_elap == int'(TO) - 1) model_report(1, p);
                else begin
                    m_pts = p;
                    m_elap++;
                end
            end
            m_prev = sw_sweep_done;
        end
    end

    always @(negedge clk) begin
        if (reset_n && req_ready != '0) grants.push_back(req_ready[1] ? 1 : 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int who);
        who = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                who = req_ready[1] ? 1 : 0;
                break;
            end
        end
        step();
    endtask

    task automatic do_read(input int dly);
        bit ok;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!sw_fifo_empty) begin
                ok = 1;
                break;
            end
        end
        chk("offer_seen", ok, 1);
        repeat (dly) step();
        sw_fifo_rd_en = 1'b1;
        step();
        sw_fifo_rd_en = 1'b0;
    endtask

    task automatic do_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            pd_data_valid = 1'b1;
            step();
            pd_data_valid = 1'b0;
            step();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_empty"}, sw_fifo_empty, 1);
        chk({tag, "_data"}, sw_fifo_data, 80'd0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_dvalid"}, done_valid, 0);
        chk({tag, "_did"}, done_id, 0);
        chk({tag, "_dpts"}, done_points, 0);
        chk({tag, "_derr"}, done_err, 0);
    endtask

    initial begin
        int who;
        int cnt;
        bit seen;
        int exp_order[4];

        reset_n = 1'b0; req_valid = '0; req_data = '0;
        sw_fifo_rd_en = 1'b0; sw_sweep_done = 1'b0; pd_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        step();
        reset_n = 1'b1;
        step();

        // Single sweep from requester 0: 10 points, clean completion.
        req_data[79:0] = I0;
        req_valid = 2'b01;
        wait_grant(who);
        chk("t1_grant", who, 0);
        req_valid = '0;
        @(negedge clk);
        chk("t1_empty", sw_fifo_empty, 0);
        chk("t1_data", sw_fifo_data, 80'h0100_0000_0004_0001_0000);
        do_read(3);
        do_pulses(10);
        sw_sweep_done = 1'b1;
        step();
        @(negedge clk);
        chk("t1_dvalid", done_valid, 1);
        chk("t1_did", done_id, 0);
        chk("t1_dpts", done_points, 10);
        chk("t1_derr", done_err, 0);
        step();
        sw_sweep_done = 1'b0;
        chk("t1_ngrants", grants.size(), 1);

        // Rejected instruction from requester 1.
        req_data[159:80] = IREJ;
        req_valid = 2'b10;
        wait_grant(who);
        chk("rej_grant", who, 1);
        req_valid = '0;
        @(negedge clk);
        chk("rej_dvalid", done_valid, 1);
        chk("rej_did", done_id, 1);
        chk("rej_derr", done_err, 2'b10);
        chk("rej_dpts", done_points, 0);
        chk("rej_empty", sw_fifo_empty, 1);
        step();

        // Fairness: both requesters pending for four sweeps.
        grants.delete();
        exp_order = '{0, 1, 0, 1};
        req_data[79:0]   = I0;
        req_data[159:80] = I1;
        req_valid = 2'b11;
        for (int s = 0; s < 4; s++) begin
            wait_grant(who);
            do_read(1);
            do_pulses(2);
            sw_sweep_done = 1'b1;
            step();
            @(negedge clk);
            chk("fair_dvalid", done_valid, 1);
            chk("fair_did", done_id, exp_order[s]);
            step();
            sw_sweep_done = 1'b0;
            if (s == 3) req_valid = '0;
        end
        chk("fair_ngrants", grants.size(), 4);
        for (int s = 0; s < 4; s++) begin
            if (s < grants.size()) chk("fair_order", grants[s], exp_order[s]);
        end

        // Sweeper never completes.
        req_valid = 2'b01;
        wait_grant(who);
        chk("to_grant", who, 0);
        req_valid = '0;
        do_read(2);
        cnt = -1;
        for (int k = 0; k <= 1000; k++) begin
            pd_data_valid = (k == 2 || k == 5 || k == 7);
            @(negedge clk);
            if (done_valid) begin
                cnt = k;
                break;
            end
            step();
        end
        pd_data_valid = 1'b0;
        if (TO_EN) begin
            chk("to_latency", cnt, 100);
            chk("to_derr", done_err, 2'b01);
            chk("to_dpts", done_points, 3);
            step();
        end else begin
            chk("to_no_done", cnt, -1);
            sw_sweep_done = 1'b1;
            step();
            @(negedge clk);
            chk("to_dvalid", done_valid, 1);
            chk("to_dpts", done_points, 3);
            step();
            sw_sweep_done = 1'b0;
        end

        // Reset in the middle of RUN.
        req_valid = 2'b01;
        wait_grant(who);
        chk("rst_grant0", who, 0);
        req_valid = '0;
        do_read(1);
        do_pulses(2);
        req_valid = 2'b11;
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid");
        step();
        step();
        reset_n = 1'b1;
        wait_grant(who);
        chk("rst_first_grant", who, 0);
        req_valid = '0;
        do_read(1);
        sw_sweep_done = 1'b1;
        step();
        @(negedge clk);
        chk("rst_dvalid", done_valid, 1);
        step();
        sw_sweep_done = 1'b0;

        // Done level left high from the previous sweep.
        req_valid = 2'b01;
        wait_grant(who);
        req_valid = '0;
        do_read(1);
        do_pulses(1);
        sw_sweep_done = 1'b1;
        step();
        @(negedge clk);
        chk("stale_prev_dvalid", done_valid, 1);
        step();
        req_valid = 2'b10;
        wait_grant(who);
        chk("stale_grant", who, 1);
        req_valid = '0;
        do_read(1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            pd_data_valid = (k == 1 || k == 3);
            @(negedge clk);
            if (done_valid) seen = 1;
            step();
        end
        pd_data_valid = 1'b0;
        chk("stale_no_done", seen, 0);
        sw_sweep_done = 1'b0;
        step();
        step();
        sw_sweep_done = 1'b1;
        step();
        @(negedge clk);
        chk("stale_dvalid", done_valid, 1);
        chk("stale_did", done_id, 1);
        chk("stale_dpts", done_points, 2);
        chk("stale_derr", done_err, 0);
        step();
        sw_sweep_done = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
